led_blink_driver: RTL
=====================

Name: led_blink_driver

Overview:
- Output-side counterpart of the button debouncer. The debouncer turns a noisy human input into one-cycle event pulses; this block turns one-cycle event pulses into human-visible LED blinks.
- Each accepted pulse produces exactly one blink: a fixed ON time followed by a fixed OFF gap.
- Pulses arriving during a blink are queued in a saturating counter, so back-to-back events stay visually distinct.
- Sits in the IO group between event sources (debouncer, status logic) and board LED pins.

Parameters:
- ON_CYCLES, 16, clock cycles led_out is held high per blink; must be >= 1.
- OFF_CYCLES, 8, clock cycles led_out is held low between queued blinks; must be >= 1.
- PEND_W, 4, width of the pending-event counter; maximum queued events = 2^PEND_W - 1.
- TMR_W, 16, width of the cycle timer; must hold max(ON_CYCLES, OFF_CYCLES) - 1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- event_pulse  input  1  event request; each cycle sampled high counts as one event (a 3-cycle-high input = 3 events).
- led_out  output  1  registered LED drive, high during ON phase.
- busy  output  1  high whenever state != IDLE.
- pending_count  output  PEND_W  number of queued, not yet started blinks.
- overflow  output  1  sticky; set when an event is dropped at saturation.

Behaviour:
- Reset (async, rst=1): state=IDLE, led_out=0, busy=0, pending_count=0, overflow=0, timer=0. Outputs go low immediately on rst assertion, including mid-blink; the blink is abandoned and the queue cleared.
- FSM states: IDLE, ON, GAP. All outputs are registered.
- IDLE, event_pulse=1 at edge k: ON, led_out=1 from edge k, timer=ON_CYCLES-1. Latency is one edge. led_out is high for exactly ON_CYCLES cycles.
- ON: timer decrements each edge. At the edge where timer==0: GAP, led_out=0, timer=OFF_CYCLES-1.
- GAP: timer decrements each edge. At the edge where timer==0:
  - pending_count>0: ON, timer reload, pending_count-1.
  - else event_pulse=1 on this edge: ON directly; the event is consumed, no IDLE cycle.
  - else: IDLE.
- event_pulse=1 in ON or GAP (not consumed by the GAP exit rule): pending_count+1.
  - If pending_count is already at max, hold at max and set overflow=1.
- Simultaneous enqueue and dequeue at GAP exit with pending_count>0: net count unchanged, overflow not set, even when at max.
- overflow is cleared only by rst.
- busy=1 in ON and GAP, 0 in IDLE.
- No blink is shortened: ON and GAP durations are exact regardless of input activity.

Decomposition:
- Shared IO header (io-defs.vh): FSM state encodings LBD_IDLE=2'd0, LBD_ON=2'd1, LBD_GAP=2'd2.
- One natural sub-module: cycle_timer.
  - Loadable down-counter, TMR_W bits.
  - Inputs: load, load_value, en. Output: done when count==0.
  - Async active-high reset to 0.
  - Reusable by the debouncer for its stability window.
- Queue counter and FSM stay in the top module.

Test Plan:
- Defaults, single event_pulse at edge 10 -> led_out high for exactly 16 cycles starting edge 10, then 8 low cycles; then IDLE, busy=0, pending_count=0.
- Three one-cycle pulses at edges 10, 12, 14 -> pending_count goes 1 then 2. Three blinks of 16 high separated by exactly 8 low; pending_count drains 2 -> 1 -> 0 at GAP exits.
- event_pulse held high 20 cycles during an ON phase with PEND_W=4 -> pending_count saturates at 15 and overflow=1. Exactly 16 blinks total, overflow stays 1 afterwards.
- Pulse on the exact edge GAP ends with pending_count=0 -> next ON starts on that edge with no IDLE cycle; pending_count remains 0.
- rst asserted asynchronously mid-ON with pending_count=3 -> led_out, busy, pending_count and overflow go to 0 without waiting for a clock edge. After release, a new pulse gives a full 16-cycle blink.
- ON_CYCLES=1, OFF_CYCLES=1, continuous event_pulse -> led_out toggles 1,0,1,0 each cycle; pending_count rises then saturates; no glitch or missed blink.

Source files
------------

// File: rtl/led_blink_driver_pkg.sv
// Shared definitions for the LED blink driver: FSM state encodings.
package led_blink_driver_pkg;

  typedef enum logic [1:0] {
    LBD_IDLE = 2'd0,
    LBD_ON   = 2'd1,
    LBD_GAP  = 2'd2
  } lbd_state_e;

endpackage : led_blink_driver_pkg

// File: rtl/led_blink_driver_cycle_timer.sv
// Loadable down-counter with a registered done flag (count == 0).
module cycle_timer #(
  parameter int unsigned TMR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_value,
  input  logic             en,
  output logic             done
);

  logic [TMR_W-1:0] count;

  // Counter holds at zero; done tracks the value count takes after each edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      done  <= 1'b1;
    end else if (load) begin
      count <= load_value;
      done  <= (load_value == '0);
    end else if (en && (count != '0)) begin
      count <= count - TMR_W'(1);
      done  <= (count == TMR_W'(1));
    end
  end

endmodule : cycle_timer

// File: rtl/led_blink_driver.sv
// Turns one-cycle event pulses into fixed ON/GAP LED blinks, queueing
// events that arrive mid-blink in a saturating pending counter.
module led_blink_driver
  import led_blink_driver_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = 16,
  parameter int unsigned OFF_CYCLES = 8,
  parameter int unsigned PEND_W     = 4,
  parameter int unsigned TMR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              event_pulse,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending_count,
  output logic              overflow
);

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [TMR_W-1:0]  ON_LOAD  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0]  OFF_LOAD = TMR_W'(OFF_CYCLES - 1);

  lbd_state_e        state, state_nxt;
  logic [PEND_W-1:0] pend_nxt;
  logic              ovf_nxt;
  logic              tmr_load, tmr_en, tmr_done;
  logic [TMR_W-1:0]  tmr_val;
  logic              enq, deq;

  cycle_timer #(.TMR_W(TMR_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .load_value (tmr_val),
    .en         (tmr_en),
    .done       (tmr_done)
  );

  // Next state, timer control and queue update.
  always_comb begin
    state_nxt = state;
    pend_nxt  = pending_count;
    ovf_nxt   = overflow;
    tmr_load  = 1'b0;
    tmr_val   = ON_LOAD;
    tmr_en    = 1'b0;
    enq       = 1'b0;
    deq       = 1'b0;
    case (state)
      LBD_IDLE: begin
        if (event_pulse) begin
          state_nxt = LBD_ON;
          tmr_load  = 1'b1;
        end
      end
      LBD_ON: begin
        enq = event_pulse;
        if (tmr_done) begin
          state_nxt = LBD_GAP;
          tmr_load  = 1'b1;
          tmr_val   = OFF_LOAD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      LBD_GAP: begin
        if (tmr_done) begin
          // Queued work wins; a fresh pulse with an empty queue is consumed directly.
          if (pending_count != '0) begin
            deq       = 1'b1;
            enq       = event_pulse;
            state_nxt = LBD_ON;
            tmr_load  = 1'b1;
          end else if (event_pulse) begin
            state_nxt = LBD_ON;
            tmr_load  = 1'b1;
          end else begin
            state_nxt = LBD_IDLE;
          end
        end else begin
          enq    = event_pulse;
          tmr_en = 1'b1;
        end
      end
      default: state_nxt = LBD_IDLE;
    endcase

    if (enq && !deq) begin
      if (pending_count == PEND_MAX) ovf_nxt = 1'b1;
      else                           pend_nxt = pending_count + PEND_W'(1);
    end else if (deq && !enq) begin
      pend_nxt = pending_count - PEND_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= LBD_IDLE;
      led_out       <= 1'b0;
      busy          <= 1'b0;
      pending_count <= '0;
      overflow      <= 1'b0;
    end else begin
      state         <= state_nxt;
      led_out       <= (state_nxt == LBD_ON);
      busy          <= (state_nxt != LBD_IDLE);
      pending_count <= pend_nxt;
      overflow      <= ovf_nxt;
    end
  end

endmodule : led_blink_driver
